// File: rtl/perceptron_train_sequencer.sv
// ----------------------------------------------------------------------------
// perceptron_train_sequencer
//
// Autonomous training/evaluation controller for a single-layer perceptron.
// A small sample set is loaded through a write port while idle. On start the
// sequencer runs epochs. Each epoch is one train pass followed by one eval
// pass:
//   - train pass: one cycle per sample, with training=1
//   - eval pass:  each sample held PRED_LATENCY+1 cycles, with training=0
// During the eval pass it counts how many predictions match the labels.
//
// Optional build macro:
//   PERCEPTRON_SEQ_EARLY_STOP_EN - when defined, a run ends as soon as an
//   eval pass classifies every sample correctly. When undefined, a run always
//   lasts max_epochs epochs.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   wr_en         sample write strobe (honoured only while idle)
//   wr_addr       sample slot to write
//   wr_values     sample inputs, INPUT_UNITS x 64-bit Q32.32
//   wr_expected   sample label, 64-bit Q32.32
//   num_samples   active sample count, latched on start
//   max_epochs    epoch limit, latched on start
//   start         one-cycle run request (ignored while busy)
//   prediction    perceptron output, PRED_LATENCY cycles after the inputs
//   values        perceptron inputs
//   expected      perceptron label
//   training      perceptron weight-update enable
//   busy          high while a run is in progress
//   done          one-cycle pulse on returning to idle from a run
//   epoch         number of completed epochs
//   correct       match count of the last completed eval pass
//   converged     last eval pass matched every sample
// ----------------------------------------------------------------------------
module perceptron_train_sequencer #(
  parameter int INPUT_UNITS  = 2,
  parameter int MAX_SAMPLES  = 8,
  parameter int PRED_LATENCY = 1,
  parameter int EPOCH_W      = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_en,
  input  logic [$clog2(MAX_SAMPLES)-1:0]      wr_addr,
  input  logic [INPUT_UNITS-1:0][63:0]        wr_values,
  input  logic [63:0]                         wr_expected,
  input  logic [$clog2(MAX_SAMPLES):0]        num_samples,
  input  logic [EPOCH_W-1:0]                  max_epochs,
  input  logic                                start,
  input  logic [63:0]                         prediction,
  output logic [INPUT_UNITS-1:0][63:0]        values,
  output logic [63:0]                         expected,
  output logic                                training,
  output logic                                busy,
  output logic                                done,
  output logic [EPOCH_W-1:0]                  epoch,
  output logic [$clog2(MAX_SAMPLES):0]        correct,
  output logic                                converged
);

  localparam int IW = $clog2(MAX_SAMPLES);
  localparam int CW = IW + 1;
  localparam int HW = 3;
  // Last hold cycle of an eval sample: prediction for it is valid here.
  localparam logic [HW-1:0] HOLD_LAST = HW'(PRED_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRAIN = 2'd1,
    S_EVAL  = 2'd2
  } state_t;

  // Sample memory (deliberately not reset)
  logic [INPUT_UNITS-1:0][63:0] mem_values_r   [MAX_SAMPLES];
  logic [63:0]                  mem_expected_r [MAX_SAMPLES];

  // Control state
  state_t            state_r,     state_s;
  logic [IW-1:0]     idx_r,       idx_s;
  logic [HW-1:0]     hold_r,      hold_s;
  logic [CW-1:0]     run_cnt_r,   run_cnt_s;
  logic [CW-1:0]     ns_r,        ns_s;
  logic [EPOCH_W-1:0] me_r,       me_s;

  // Registered outputs
  logic [EPOCH_W-1:0]           epoch_r,     epoch_s;
  logic [CW-1:0]                correct_r,   correct_s;
  logic                         converged_r, converged_s;
  logic                         done_r,      done_s;
  logic                         busy_r,      busy_s;
  logic                         training_r,  training_s;
  logic [INPUT_UNITS-1:0][63:0] values_r,    values_s;
  logic [63:0]                  expected_r,  expected_s;

  // Helper terms
  logic               last_idx_s;
  logic               match_s;
  logic [CW-1:0]      cnt_final_s;
  logic               conv_final_s;
  logic [EPOCH_W:0]   epoch_inc_s;
  logic               stop_s;
  logic [CW-1:0]      ns_clamp_s;

  assign values    = values_r;
  assign expected  = expected_r;
  assign training  = training_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign epoch     = epoch_r;
  assign correct   = correct_r;
  assign converged = converged_r;

  // Sample memory write port, open only while idle
  always_ff @(posedge clk) begin
    if (wr_en && !rst && (state_r == S_IDLE)) begin
      mem_values_r[wr_addr]   <= wr_values;
      mem_expected_r[wr_addr] <= wr_expected;
    end
  end

  // Next-state, counters and next output values
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    hold_s      = hold_r;
    run_cnt_s   = run_cnt_r;
    ns_s        = ns_r;
    me_s        = me_r;
    epoch_s     = epoch_r;
    correct_s   = correct_r;
    converged_s = converged_r;
    done_s      = 1'b0;

    last_idx_s   = ({1'b0, idx_r} == (ns_r - CW'(1)));
    // The label is still held on the last hold cycle, so compare against it.
    match_s      = (prediction == expected_r);
    cnt_final_s  = run_cnt_r + (match_s ? CW'(1) : CW'(0));
    conv_final_s = (cnt_final_s == ns_r);
    epoch_inc_s  = {1'b0, epoch_r} + (EPOCH_W + 1)'(1);
    // A request larger than the memory runs over the whole memory.
    ns_clamp_s   = (num_samples > CW'(MAX_SAMPLES)) ? CW'(MAX_SAMPLES) : num_samples;

`ifdef PERCEPTRON_SEQ_EARLY_STOP_EN
    stop_s = (epoch_inc_s == {1'b0, me_r}) || conv_final_s;
`else
    stop_s = (epoch_inc_s == {1'b0, me_r});
`endif

    case (state_r)
      S_IDLE: begin
        if (start) begin
          epoch_s     = '0;
          correct_s   = '0;
          converged_s = 1'b0;
          if ((num_samples == '0) || (max_epochs == '0)) begin
            done_s = 1'b1;
          end else begin
            ns_s    = ns_clamp_s;
            me_s    = max_epochs;
            idx_s   = '0;
            state_s = S_TRAIN;
          end
        end else begin
          state_s = S_IDLE;
        end
      end

      S_TRAIN: begin
        if (last_idx_s) begin
          state_s   = S_EVAL;
          idx_s     = '0;
          hold_s    = '0;
          run_cnt_s = '0;
        end else begin
          idx_s = idx_r + IW'(1);
        end
      end

      S_EVAL: begin
        if (hold_r != HOLD_LAST) begin
          hold_s = hold_r + HW'(1);
        end else begin
          hold_s    = '0;
          run_cnt_s = cnt_final_s;
          if (!last_idx_s) begin
            idx_s = idx_r + IW'(1);
          end else begin
            // End of the eval pass: publish results and close the epoch.
            correct_s   = cnt_final_s;
            converged_s = conv_final_s;
            epoch_s     = (epoch_r == {EPOCH_W{1'b1}}) ? epoch_r : epoch_r + EPOCH_W'(1);
            idx_s       = '0;
            if (stop_s) begin
              state_s = S_IDLE;
              done_s  = 1'b1;
            end else begin
              state_s = S_TRAIN;
            end
          end
        end
      end

      default: begin
        state_s = S_IDLE;
      end
    endcase

    // Outputs reflect the state being entered, so they line up with it.
    busy_s     = (state_s != S_IDLE);
    training_s = (state_s == S_TRAIN);
    if (state_s != S_IDLE) begin
      values_s   = mem_values_r[idx_s];
      expected_s = mem_expected_r[idx_s];
    end else begin
      values_s   = '0;
      expected_s = 64'd0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      idx_r       <= '0;
      hold_r      <= '0;
      run_cnt_r   <= '0;
      ns_r        <= '0;
      me_r        <= '0;
      epoch_r     <= '0;
      correct_r   <= '0;
      converged_r <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      training_r  <= 1'b0;
      values_r    <= '0;
      expected_r  <= 64'd0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      hold_r      <= hold_s;
      run_cnt_r   <= run_cnt_s;
      ns_r        <= ns_s;
      me_r        <= me_s;
      epoch_r     <= epoch_s;
      correct_r   <= correct_s;
      converged_r <= converged_s;
      done_r      <= done_s;
      busy_r      <= busy_s;
      training_r  <= training_s;
      values_r    <= values_s;
      expected_r  <= expected_s;
    end
  end

endmodule

// File: doc/perceptron_train_sequencer.md
Name: perceptron_train_sequencer

Overview:
- Autonomous training/evaluation controller for the single-layer perceptron. It drives `values`, `expected` and `training` each cycle and reads `prediction`.
- Holds a small on-chip sample set loaded over a write port. It runs train-pass/eval-pass epochs, counts correct classifications and stops at max epochs (or on convergence when the optional feature is built in).
- Replaces hand-written bench stimulus loops; sits between the host/config logic and the perceptron instance.

Parameters:
- INPUT_UNITS, 2, number of perceptron inputs (width of the `values` array).
- MAX_SAMPLES, 8, depth of the sample memory.
- PRED_LATENCY, 1, cycles from inputs driven to a valid `prediction` (1..4).
- EPOCH_W, 8, width of the epoch counter and `max_epochs`.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wr_en  in  1  sample write strobe; accepted only in IDLE
- wr_addr  in  $clog2(MAX_SAMPLES)  sample slot written
- wr_values  in  sfp[INPUT_UNITS]  sample inputs (Q32.32, 64 bit)
- wr_expected  in  sfp  sample label
- num_samples  in  $clog2(MAX_SAMPLES)+1  active samples; sampled at start
- max_epochs  in  EPOCH_W  epoch limit; sampled at start
- start  in  1  one-cycle pulse; ignored unless IDLE
- values  out  sfp[INPUT_UNITS]  to perceptron
- expected  out  sfp  to perceptron
- training  out  1  to perceptron; 1 = weight update enabled this cycle
- busy  out  1  high in TRAIN/EVAL
- done  out  1  one-cycle pulse on entering IDLE from a run
- epoch  out  EPOCH_W  completed epochs
- correct  out  $clog2(MAX_SAMPLES)+1  correct count of the last completed eval pass
- converged  out  1  last eval pass had correct == num_samples

Behaviour:
- Reset values: all outputs 0, state IDLE, sample memory unchanged.
- Sample memory is not cleared by reset.
- IDLE:
  - values = 0, expected = 0, training = 0.
  - wr_en writes the slot in the same cycle.
  - start with num_samples==0 or max_epochs==0: pulse done next cycle; epoch, correct and converged all cleared; no TRAIN.
  - Otherwise start: latch num_samples/max_epochs, clear epoch/correct/converged, go to TRAIN at idx 0.
- TRAIN:
  - Each cycle drive sample idx with training=1, then idx++.
  - After idx == num_samples-1, go to EVAL at idx 0 with a zeroed running count.
- EVAL:
  - Drive sample idx with training=0, held PRED_LATENCY+1 cycles.
  - On the last hold cycle, compare `prediction == expected` (full 64-bit equality); increment the running count on a match.
  - After the last sample: correct <= running count (including the final compare), converged <= (count == num_samples), epoch++.
  - Then TRAIN again, or IDLE with done if epoch+1 == max_epochs.
- Cycles per epoch = N + N*(PRED_LATENCY+1).
- epoch saturates at its maximum and is never compared past max_epochs.
- wr_en outside IDLE: ignored.
- start while busy: ignored.
- rst mid-run: back to IDLE next edge with training=0; no done pulse.
- Writes to addresses >= num_samples are harmless.

Optional Feature:
- PERCEPTRON_SEQ_EARLY_STOP_EN defined: after any eval pass with converged=1, go to IDLE and pulse done immediately, even if epoch < max_epochs.
- Undefined: always run exactly max_epochs epochs; converged is still reported.

Test Plan:
- AND-gate set ([0,0]->0, [0,1]->0, [1,0]->0, [1,1]->ONE=2^32), num_samples=4, max_epochs=10, learning-rate ONE, real perceptron:
  - done after 10 epochs (no early stop), correct=4, converged=1.
  - training high exactly 4 consecutive cycles per epoch.
- Stub perceptron, prediction = registered expected, PRED_LATENCY=1:
  - each eval sample held 2 cycles.
  - correct=4 after epoch 1; epoch increments 0->1 at the end of the first eval pass.
- Stub forcing prediction wrong for sample 2 only -> correct=3, converged=0. With PERCEPTRON_SEQ_EARLY_STOP_EN the run lasts the full max_epochs=3.
- With PERCEPTRON_SEQ_EARLY_STOP_EN and the correct stub, max_epochs=10 -> done pulse after epoch=1; busy drops the same cycle.
- rst asserted mid-TRAIN (epoch 2, idx 1):
  - next cycle busy=0, training=0, epoch=0, no done.
  - sample memory still holds the AND set; a new start reruns it.
- num_samples=0 start -> done pulse next cycle, busy never high. wr_en and start while busy -> memory unchanged, run unaffected.
